// File: rtl/fence_flush_sequencer.sv
// fence_flush_sequencer: on a committed FENCE / FENCE.I / SFENCE.VMA, walks the
// required cache, L2 and TLB maintenance handshakes in order. It then issues a
// single pipeline-flush pulse and returns to idle.
module fence_flush_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fence_req_i,
    input  logic             fence_i_req_i,
    input  logic             sfence_vma_req_i,
    input  logic [1:0]       fence_op_i,
    output logic             busy_o,
    output logic             flush_dcache_o,
    input  logic             flush_dcache_ack_i,
    output logic             l2_fence_req_o,
    output logic [1:0]       l2_fence_op_o,
    input  logic             l2_fence_ack_i,
    output logic             flush_icache_o,
    output logic             flush_tlb_o,
    output logic             flush_pipeline_o,
    output logic             timeout_o,
    input  logic             timeout_clr_i,
    output logic [CNT_W-1:0] fence_cnt_o
);

    // Keep the watchdog at least one bit wide so TIMEOUT=0 still elaborates cleanly.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        DC_FLUSH,
        L2_FENCE,
        IC_FLUSH,
        TLB_FLUSH,
        DONE
    } state_t;

    state_t            state, state_n;
    logic              is_fence_i;   // remembers FENCE.I vs FENCE for the exit from DC_FLUSH
    logic [WD_W-1:0]   wd;
    logic              wd_expired;
    logic              timeout_set;

    assign wd_expired = (TIMEOUT != 0) && (wd == WD_LAST);

    // Next-state logic; an ack on the expiry cycle takes precedence over the watchdog.
    always_comb begin
        state_n     = state;
        timeout_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (fence_i_req_i || fence_req_i) state_n = DC_FLUSH;
                else if (sfence_vma_req_i)        state_n = TLB_FLUSH;
            end
            DC_FLUSH: begin
                if (flush_dcache_ack_i || wd_expired) begin
                    timeout_set = !flush_dcache_ack_i;
                    if (is_fence_i)                 state_n = IC_FLUSH;
                    else if (l2_fence_op_o != 2'b00) state_n = L2_FENCE;
                    else                            state_n = DONE;
                end
            end
            L2_FENCE: begin
                if (l2_fence_ack_i || wd_expired) begin
                    timeout_set = !l2_fence_ack_i;
                    state_n     = DONE;
                end
            end
            IC_FLUSH:  state_n = DONE;
            TLB_FLUSH: state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Capture request kind and fence op when a request is accepted in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_fence_i    <= 1'b0;
            l2_fence_op_o <= 2'b00;
        end else if (state == IDLE && (fence_i_req_i || fence_req_i || sfence_vma_req_i)) begin
            is_fence_i    <= fence_i_req_i;
            l2_fence_op_o <= (!fence_i_req_i && fence_req_i) ? fence_op_i : 2'b00;
        end
    end

    // Watchdog: restarts on every state change, counts waiting cycles in handshake states.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                         wd <= '0;
        else if (state_n != state)                         wd <= '0;
        else if (state == DC_FLUSH || state == L2_FENCE)   wd <= wd + 1'b1;
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              timeout_o <= 1'b0;
        else if (timeout_set)   timeout_o <= 1'b1;
        else if (timeout_clr_i) timeout_o <= 1'b0;
    end

    // Completed-sequence counter, wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              fence_cnt_o <= '0;
        else if (state == DONE) fence_cnt_o <= fence_cnt_o + 1'b1;
    end

    assign busy_o           = (state != IDLE);
    assign flush_dcache_o   = (state == DC_FLUSH);
    assign l2_fence_req_o   = (state == L2_FENCE);
    assign flush_icache_o   = (state == IC_FLUSH);
    assign flush_tlb_o      = (state == TLB_FLUSH);
    assign flush_pipeline_o = (state == DONE);

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Directed bench for fence_flush_sequencer (TIMEOUT=8, CNT_W=4).
module tb_fence_flush_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fence_req, fence_i_req, sfence_req;
    logic [1:0] fence_op;
    logic       busy, flush_dc, dc_ack, l2_req, l2_ack;
    logic [1:0] l2_op;
    logic       flush_ic, flush_tlb, flush_pl, timeout, timeout_clr;
    logic [3:0] cnt;

    int n_chk = 0;
    int n_err = 0;

    // Per-sequence observations gathered by the monitor.
    int busy_n, dc_n, l2_n, ic_n, tlb_n, pl_n, op_bad, tlb_first, pl_first;

    fence_flush_sequencer #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .fence_req_i(fence_req), .fence_i_req_i(fence_i_req), .sfence_vma_req_i(sfence_req),
        .fence_op_i(fence_op), .busy_o(busy),
        .flush_dcache_o(flush_dc), .flush_dcache_ack_i(dc_ack),
        .l2_fence_req_o(l2_req), .l2_fence_op_o(l2_op), .l2_fence_ack_i(l2_ack),
        .flush_icache_o(flush_ic), .flush_tlb_o(flush_tlb), .flush_pipeline_o(flush_pl),
        .timeout_o(timeout), .timeout_clr_i(timeout_clr), .fence_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue a one-cycle request; returns at the negedge after the accepting edge.
    task automatic issue(input logic f, input logic fi, input logic sv, input logic [1:0] op);
        @(negedge clk);
        fence_req = f; fence_i_req = fi; sfence_req = sv; fence_op = op;
        @(negedge clk);
        fence_req = 0; fence_i_req = 0; sfence_req = 0; fence_op = 0;
    endtask

    // Sample each cycle at negedge, acking the k-th cycle of a handshake (0 = never).
    // A fence request can be injected at sample index inj (-1 = none).
    task automatic monitor(input int dc_lat, input int l2_lat, input logic [1:0] exp_op, input int inj);
        int  dcs = 0, l2s = 0;
        bit  seen = 0, fin = 0;
        busy_n = 0; dc_n = 0; l2_n = 0; ic_n = 0; tlb_n = 0; pl_n = 0; op_bad = 0;
        tlb_first = -1; pl_first = -1;
        for (int i = 0; i < 40; i++) begin
            if (seen && !busy) begin fin = 1; break; end
            if (busy) begin seen = 1; busy_n++; end
            if (flush_dc) begin dc_n++; dcs++; end
            if (l2_req) begin l2_n++; l2s++; if (l2_op != exp_op) op_bad++; end
            if (flush_ic) ic_n++;
            if (flush_tlb) begin tlb_n++; if (tlb_first < 0) tlb_first = i; end
            if (flush_pl) begin pl_n++; if (pl_first < 0) pl_first = i; end
            dc_ack    = flush_dc && dc_lat != 0 && dcs == dc_lat;
            l2_ack    = l2_req && l2_lat != 0 && l2s == l2_lat;
            fence_req = (i == inj);
            fence_op  = 2'b00;
            @(negedge clk);
        end
        dc_ack = 0; l2_ack = 0; fence_req = 0;
        if (!fin) chk("seq_bound", 0, 1);
    endtask

    initial begin
        rst = 1; fence_req = 0; fence_i_req = 0; sfence_req = 0; fence_op = 0;
        dc_ack = 0; l2_ack = 0; timeout_clr = 0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {busy, flush_dc, l2_req, flush_ic, flush_tlb, flush_pl, timeout}, 0);
        chk("rst_cnt", cnt, 0);
        rst = 0;

        // 1: FENCE op=3, D$ ack on 3rd cycle, L2 ack on 2nd cycle
        issue(1, 0, 0, 2'b11);
        monitor(3, 2, 2'b11, -1);
        chk("t1_dc", dc_n, 3);
        chk("t1_l2", l2_n, 2);
        chk("t1_op", op_bad, 0);
        chk("t1_pl", pl_n, 1);
        chk("t1_busy", busy_n, 6);
        chk("t1_cnt", cnt, 1);

        // 2: FENCE.I and SFENCE.VMA together -> FENCE.I only
        issue(0, 1, 1, 2'b00);
        monitor(1, 0, 2'b00, -1);
        chk("t2_dc", dc_n, 1);
        chk("t2_ic", ic_n, 1);
        chk("t2_tlb", tlb_n, 0);
        chk("t2_l2", l2_n, 0);
        chk("t2_pl", pl_n, 1);
        chk("t2_cnt", cnt, 2);

        // 3a: D$ ack never returns -> watchdog after 8 cycles
        issue(1, 0, 0, 2'b00);
        monitor(0, 0, 2'b00, -1);
        chk("t3_dc", dc_n, 8);
        chk("t3_busy", busy_n, 9);
        chk("t3_to_sticky", timeout, 1);
        @(negedge clk); timeout_clr = 1;
        @(negedge clk); timeout_clr = 0;
        chk("t3_to_clr", timeout, 0);
        // 3b: ack on the expiry cycle wins
        issue(1, 0, 0, 2'b00);
        monitor(8, 0, 2'b00, -1);
        chk("t3b_dc", dc_n, 8);
        chk("t3b_to", timeout, 0);
        chk("t3b_cnt", cnt, 4);

        // 4: reset while in L2_FENCE
        issue(1, 0, 0, 2'b01);
        begin
            bit hit = 0;
            for (int i = 0; i < 20; i++) begin
                if (l2_req) begin hit = 1; break; end
                dc_ack = flush_dc;
                @(negedge clk);
            end
            dc_ack = 0;
            chk("t4_reach_l2", hit, 1);
        end
        @(negedge clk);
        #2 rst = 1;
        #1 chk("t4_async_outs", {busy, flush_dc, l2_req, flush_ic, flush_tlb, flush_pl, timeout, l2_op}, 0);
        chk("t4_async_cnt", cnt, 0);
        @(negedge clk); rst = 0; l2_ack = 1;
        repeat (2) @(negedge clk);
        chk("t4_late_ack", {busy, l2_req, flush_pl}, 0);
        l2_ack = 0;
        issue(0, 0, 1, 2'b00);
        monitor(0, 0, 2'b00, -1);
        chk("t4_tlb_at", tlb_first, 0);
        chk("t4_pl_at", pl_first, 1);
        chk("t4_tlb_n", tlb_n, 1);
        chk("t4_cnt", cnt, 1);

        // 5: fence request while busy is ignored
        issue(0, 1, 0, 2'b00);
        monitor(3, 0, 2'b00, 1);
        chk("t5_dc", dc_n, 3);
        chk("t5_ic", ic_n, 1);
        chk("t5_pl", pl_n, 1);
        repeat (2) @(negedge clk);
        chk("t5_idle", busy, 0);
        chk("t5_cnt", cnt, 2);
        // counter wrap
        for (int k = 0; k < 13; k++) begin
            issue(0, 0, 1, 2'b00);
            monitor(0, 0, 2'b00, -1);
        end
        chk("t5_cnt_max", cnt, 15);
        issue(0, 0, 1, 2'b00);
        monitor(0, 0, 2'b00, -1);
        chk("t5_cnt_wrap", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
